// File: rtl/mult_pipe_stage.sv
// mult_pipe_stage: elastic DEPTH-stage register chain for multiplier phase results
// Ports: clk; rst (async, active-low); flush (sync kill of in-flight entries);
//   in_valid/in_ready/in_data/in_done  upstream handshake, payload and done tag;
//   out_valid/out_ready/out_data/out_done  downstream handshake, payload and done tag;
//   occupancy  registered count of valid stages (0..DEPTH).
module mult_pipe_stage #(
   parameter int DATA_W = 65,
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_done,
   output logic [CNT_W-1:0]  occupancy
);
   logic [DEPTH-1:0] v_q, v_d, t_q, t_d, adv, src_v, src_t;
   logic [DEPTH-1:0][DATA_W-1:0] d_q, d_d, src_d;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic in_xfer, out_xfer, run;
   // A stage may advance when it or any stage downstream of it is empty, or the output drains.
   always_comb begin
      run = out_ready;
      adv = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         run = run | ~v_q[k];
         adv[k] = run;
      end
   end
   for (genvar i = 0; i < DEPTH; i++) begin : g_src
      if (i == 0) begin : g_in
         assign src_v[i] = in_valid;
         assign src_d[i] = in_data;
         assign src_t[i] = in_done;
      end else begin : g_prev
         assign src_v[i] = v_q[i-1];
         assign src_d[i] = d_q[i-1];
         assign src_t[i] = t_q[i-1];
      end
   end
   // Payload and tag only load under a valid source so bubbles leave them untouched.
   always_comb begin
      v_d = v_q;
      t_d = t_q;
      d_d = d_q;
      for (int k = 0; k < DEPTH; k++) begin
         if (adv[k]) begin
            v_d[k] = src_v[k];
            if (src_v[k] && !flush) begin
               d_d[k] = src_d[k];
               t_d[k] = src_t[k];
            end
         end
      end
      if (flush) v_d = '0;
   end
   assign in_xfer = in_valid & adv[0];
   assign out_xfer = v_q[DEPTH-1] & out_ready;
   assign occ_d = flush ? '0
                : (in_xfer & ~out_xfer) ? occ_q + CNT_W'(1)
                : (out_xfer & ~in_xfer) ? occ_q - CNT_W'(1)
                : occ_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q <= '0;
         t_q <= '0;
         d_q <= '0;
         occ_q <= '0;
      end else begin
         v_q <= v_d;
         t_q <= t_d;
         d_q <= d_d;
         occ_q <= occ_d;
      end
   end
   assign in_ready = adv[0];
   assign out_valid = v_q[DEPTH-1];
   assign out_data = d_q[DEPTH-1];
   assign out_done = t_q[DEPTH-1];
   assign occupancy = occ_q;
endmodule

// File: tb/tb_mult_pipe_stage.sv
// tb_mult_pipe_stage: directed and random checks of mult_pipe_stage against a positional queue model
module tb_mult_pipe_stage;
   localparam int DATA_W = 65;
   localparam int DEPTH = 2;
   localparam int CNT_W = $clog2(DEPTH + 1);
   logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, in_done = 1'b0, out_ready = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic in_ready, out_valid, out_done;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0] occupancy;
   int n_chk = 0, n_pass = 0;
   bit last_acc;
   // Each in-flight entry carries its stage position; entries keep program order.
   typedef struct {
      logic [DATA_W-1:0] d;
      logic t;
      int p;
   } ent_t;
   ent_t q[$];
   mult_pipe_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_done(in_done),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_done(out_done),
      .occupancy(occupancy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic cycle();
      bit ir, ov;
      int lim;
      ent_t e;
      @(negedge clk);
      ir = (q.size() < DEPTH) || out_ready;
      ov = (q.size() > 0) && (q[0].p == DEPTH - 1);
      chk("in_ready", 128'(in_ready), 128'(ir));
      chk("out_valid", 128'(out_valid), 128'(ov));
      chk("occupancy", 128'(occupancy), 128'(q.size()));
      if (ov) begin
         chk("out_data", 128'(out_data), 128'(q[0].d));
         chk("out_done", 128'(out_done), 128'(q[0].t));
      end
      @(posedge clk);
      last_acc = in_valid && ir && !flush;
      if (flush) q.delete();
      else begin
         if (ov && out_ready) void'(q.pop_front());
         for (int i = 0; i < q.size(); i++) begin
            lim = (i == 0) ? DEPTH - 1 : q[i-1].p - 1;
            q[i].p = (q[i].p + 1 < lim) ? q[i].p + 1 : lim;
         end
         if (in_valid && ir) begin
            e.d = in_data;
            e.t = in_done;
            e.p = 0;
            q.push_back(e);
         end
      end
      #1;
   endtask
   task automatic drive(input bit iv, input logic [DATA_W-1:0] d, input bit t, input bit ordy, input bit fl);
      in_valid = iv;
      in_data = d;
      in_done = t;
      out_ready = ordy;
      flush = fl;
      cycle();
   endtask
   task automatic idle(input int n);
      repeat (n) drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
   endtask
   task automatic reset_checks(input string tag);
      chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
      chk({tag, "_out_data"}, 128'(out_data), 128'(0));
      chk({tag, "_out_done"}, 128'(out_done), 128'(0));
      chk({tag, "_occupancy"}, 128'(occupancy), 128'(0));
      chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
   endtask
   initial begin
      int idx;
      repeat (2) @(posedge clk);
      #1;
      reset_checks("reset");
      rst = 1'b1;
      // streaming with done on the third entry
      drive(1'b1, DATA_W'(1), 1'b0, 1'b1, 1'b0);
      drive(1'b1, DATA_W'(2), 1'b0, 1'b1, 1'b0);
      drive(1'b1, DATA_W'(3), 1'b1, 1'b1, 1'b0);
      idle(3);
      // backpressure fill: four entries offered, each held until taken
      idx = 0;
      repeat (4) begin
         drive(1'b1, DATA_W'(32'h10 + idx), 1'b0, 1'b0, 1'b0);
         if (last_acc) idx++;
      end
      for (int n = 0; n < 20 && idx < 4; n++) begin
         drive(1'b1, DATA_W'(32'h10 + idx), 1'b0, 1'b1, 1'b0);
         if (last_acc) idx++;
      end
      idle(3);
      // bubble collapse: entry parked at the output, stage 0 empty
      drive(1'b1, DATA_W'(32'h20), 1'b0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, DATA_W'(32'h21), 1'b0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      idle(3);
      // full with simultaneous in/out transfer, back-to-back done tags
      drive(1'b1, DATA_W'(32'hA), 1'b1, 1'b0, 1'b0);
      drive(1'b1, DATA_W'(32'hB), 1'b1, 1'b0, 1'b0);
      drive(1'b1, DATA_W'(32'hC), 1'b1, 1'b1, 1'b0);
      idle(3);
      // flush with two in flight and an input offered
      drive(1'b1, DATA_W'(32'h30), 1'b0, 1'b0, 1'b0);
      drive(1'b1, DATA_W'(32'h31), 1'b0, 1'b0, 1'b0);
      drive(1'b1, DATA_W'(32'h32), 1'b1, 1'b1, 1'b1);
      idle(3);
      // async reset while full, between edges
      drive(1'b1, DATA_W'(32'h40), 1'b0, 1'b0, 1'b0);
      drive(1'b1, DATA_W'(32'h41), 1'b1, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      reset_checks("async_reset");
      q.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(1'b1, {1'b1, 32'h0, 32'h1}, 1'b1, 1'b1, 1'b0);
      idle(3);
      // randomized traffic with occasional flush
      repeat (400) begin
         drive(1'($urandom_range(0, 1)), DATA_W'({$urandom(), $urandom(), $urandom()}),
               1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      end
      idle(DEPTH + 2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mult_pipe_stage.md
Name: mult_pipe_stage

Overview:
- Parametrised elastic pipeline register chain that replaces the fixed single-stage multiplier result register between multiplier phases.
- Carries a DATA_W-bit payload plus a done tag through DEPTH stages with a valid/ready handshake, bubble collapsing and synchronous flush.
- Reports occupancy so the multiplier controller can throttle issue.

Parameters:
- DATA_W, 65, payload width (phase result incl. carry bit).
- DEPTH, 2, number of register stages, legal range 1..8.
- CNT_W, $clog2(DEPTH+1), width of occupancy output (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all in-flight entries.
- in_valid  input  1  upstream has a phase result.
- in_ready  output  1  chain can accept this cycle.
- in_data  input  DATA_W  phase result in.
- in_done  input  1  done tag in (last phase of a multiply).
- out_valid  output  1  last stage holds a valid entry.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  phase result out.
- out_done  output  1  done tag out, qualified by out_valid.
- occupancy  output  CNT_W  number of valid stages (0..DEPTH).

Behaviour:
- Reset is asynchronous and active-low on rst, in one clk domain. While rst=0:
  - all stage valids = 0;
  - all stage data = 0, done = 0;
  - out_valid = 0, out_data = 0, out_done = 0, occupancy = 0, in_ready = 1 (combinational from empty state).
- Stages are indexed 0 (input side) to DEPTH-1 (output). Stage k holds v[k], d[k], t[k].
- Advance terms (combinational):
  - adv[DEPTH-1] = ~v[DEPTH-1] | out_ready.
  - adv[k] = ~v[k] | adv[k+1] for k < DEPTH-1.
  - in_ready = adv[0]; the ready path is combinational through all stages.
- Clocked update when adv[k]=1:
  - stage k loads from stage k-1, or from the input for k=0;
  - v[k] takes the source valid (in_valid for k=0);
  - d/t load only when the source valid is 1, and otherwise hold (no toggling on bubbles).
- When adv[k]=0, stage k holds all fields.
- Bubble collapsing: an empty stage always accepts. A stall at the output therefore fills the chain fully before in_ready drops.
- Latency: DEPTH cycles from in_valid&in_ready to out_valid with out_ready held 1. Throughput is 1 entry/cycle.
- Transfers:
  - Output transfer = out_valid & out_ready.
  - Input transfer = in_valid & in_ready.
  - Both in the same cycle is legal when full, and occupancy is unchanged.
- out_data / out_done are held stable while out_valid=1 and out_ready=0.
- occupancy is registered and equals the popcount of v[] after each edge. It increments on input-only transfer, decrements on output-only transfer, and holds otherwise.
- flush=1 at an edge:
  - all v[] are cleared and occupancy = 0;
  - the input transfer in that cycle is discarded;
  - data fields hold;
  - flush has priority over all other updates.
- The done tag travels in lockstep with its payload. Back-to-back done=1 entries are preserved individually.
- DEPTH=1 degenerates to a single register with ready = ~v | out_ready.
- Reset deassertion mid-stream: the first edge after rst rises behaves as from empty. No entry survives reset.
- Unknown inputs are ignored while in_valid=0.

Test Plan:
- Streaming, DEPTH=2, out_ready=1:
  - Stimulus: in_data = 1,2,3 on consecutive cycles; done=1 on the 3rd.
  - Required: out_data 1,2,3 appears 2 cycles later on consecutive cycles; out_done=1 only with 3; occupancy peaks at 2.
- Backpressure fill:
  - Stimulus: out_ready=0 while 4 entries are offered.
  - Required: the first 2 are accepted; in_ready=0 afterwards; occupancy=2; out_data=first entry is held stable.
  - Stimulus: raise out_ready.
  - Required: the remaining entries drain in order with no loss or duplicate.
- Bubble collapse:
  - Stimulus: an entry reaches stage 1 with out_ready=0 and stage 0 empty.
  - Required: in_ready=1; the next entry is accepted into stage 0; occupancy goes 1 then 2.
- Full with simultaneous in/out transfer:
  - Stimulus: out_ready=1 and in_valid=1 with the chain full.
  - Required: occupancy stays 2; order is preserved (0xA,0xB then 0xC).
- Flush:
  - Stimulus: pulse flush with 2 entries in flight and in_valid=1.
  - Required: the next cycle has out_valid=0 and occupancy=0; the flushed input never appears at the output.
- Async reset mid-stream:
  - Stimulus: drop rst between clock edges while full.
  - Required: out_valid, out_data and occupancy go to 0 immediately.
  - Stimulus: release rst, then send 0x1_0000_0000_0000_0001 with DATA_W=65.
  - Required: it emerges intact after DEPTH cycles.
